// File: rtl/hazard_scoreboard_if.sv
// Issue/writeback/flush bundle between the ID stage and the hazard scoreboard.
interface hazard_scoreboard_if #(
  parameter int NUM_REGS = 32
);
  localparam int CW = $clog2(NUM_REGS + 1);

  logic                issue_valid_ip;
  logic [6:0]          issue_opcode_ip;
  logic [4:0]          issue_src1_addr_ip;
  logic [4:0]          issue_src2_addr_ip;
  logic [4:0]          issue_dest_addr_ip;
  logic                issue_write_reg_en_ip;
  logic [4:0]          WB_reg_dest_ip;
  logic                WB_write_reg_en_ip;
  logic                flush_ip;
  logic                stall_op;
  logic                issue_fire_op;
  logic [NUM_REGS-1:0] pending_op;
  logic [CW-1:0]       pending_cnt_op;

  modport master (
    output issue_valid_ip, issue_opcode_ip, issue_src1_addr_ip, issue_src2_addr_ip,
           issue_dest_addr_ip, issue_write_reg_en_ip, WB_reg_dest_ip, WB_write_reg_en_ip,
           flush_ip,
    input  stall_op, issue_fire_op, pending_op, pending_cnt_op
  );

  modport slave (
    input  issue_valid_ip, issue_opcode_ip, issue_src1_addr_ip, issue_src2_addr_ip,
           issue_dest_addr_ip, issue_write_reg_en_ip, WB_reg_dest_ip, WB_write_reg_en_ip,
           flush_ip,
    output stall_op, issue_fire_op, pending_op, pending_cnt_op
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register in-flight writer scoreboard for the 5-stage pipe; stall is derived from registered entries.
// Define FORWARDING_EN to stall only on load-to-use (producer is a load still in EX).
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int AGE_W    = 2
) (
  input  logic               clk,
  input  logic               reset,
  hazard_scoreboard_if.slave sb
);
  localparam int CW = $clog2(NUM_REGS + 1);
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [AGE_W-1:0] AGE_ONE = AGE_W'(1);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic [NUM_REGS-1:0]            r_pend, r_load, w_pend_nxt, w_load_nxt, w_hz;
  logic [NUM_REGS-1:0][AGE_W-1:0] r_age, w_age_nxt;
  logic [CW-1:0]                  r_cnt, w_cnt_nxt;
  logic                           w_use1, w_use2, w_hz1, w_hz2, w_stall, w_fire;

  always_comb begin
    w_use1 = 1'b0;
    w_use2 = 1'b0;
    case (sb.issue_opcode_ip)
      OPC_OP, OPC_STORE, OPC_BRANCH: begin w_use1 = 1'b1; w_use2 = 1'b1; end
      OPC_OPIMM, OPC_LOAD, OPC_JALR: w_use1 = 1'b1;
      default: ;
    endcase
  end

  // Without forwarding the RF has no write-through, so an entry still stalls in its WB cycle.
`ifdef FORWARDING_EN
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++)
      w_hz[i] = r_pend[i] & r_load[i] & (r_age[i] == AGE_ONE);
  end
`else
  always_comb w_hz = r_pend;
`endif

  assign w_hz1   = w_use1 & (sb.issue_src1_addr_ip != 5'd0) & w_hz[sb.issue_src1_addr_ip];
  assign w_hz2   = w_use2 & (sb.issue_src2_addr_ip != 5'd0) & w_hz[sb.issue_src2_addr_ip];
  assign w_stall = sb.issue_valid_ip & ~sb.flush_ip & (w_hz1 | w_hz2);
  assign w_fire  = sb.issue_valid_ip & ~w_stall & ~sb.flush_ip;

  // Set beats WB clear for the same rd: the new producer is younger than the one retiring.
  always_comb begin
    w_pend_nxt = r_pend;
    w_load_nxt = r_load;
    w_age_nxt  = r_age;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (w_fire && sb.issue_write_reg_en_ip && (sb.issue_dest_addr_ip == 5'(i))) begin
        w_pend_nxt[i] = 1'b1;
        w_load_nxt[i] = (sb.issue_opcode_ip == OPC_LOAD);
        w_age_nxt[i]  = AGE_ONE;
      end else if (r_pend[i]) begin
        if ((sb.WB_write_reg_en_ip && (sb.WB_reg_dest_ip == 5'(i))) ||
            (sb.flush_ip && (r_age[i] == AGE_ONE))) begin
          w_pend_nxt[i] = 1'b0;
          w_load_nxt[i] = 1'b0;
          w_age_nxt[i]  = '0;
        end else if (r_age[i] != AGE_MAX) begin
          w_age_nxt[i] = r_age[i] + AGE_ONE;
        end
      end
    end
    w_pend_nxt[0] = 1'b0;
    w_load_nxt[0] = 1'b0;
    w_age_nxt[0]  = '0;
  end

  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++)
      w_cnt_nxt = w_cnt_nxt + CW'(w_pend_nxt[i]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend <= '0;
      r_load <= '0;
      r_age  <= '0;
      r_cnt  <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_load <= w_load_nxt;
      r_age  <= w_age_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign sb.stall_op       = w_stall;
  assign sb.issue_fire_op  = w_fire;
  assign sb.pending_op     = r_pend;
  assign sb.pending_cnt_op = r_cnt;
endmodule
